// File: rtl/fft_pkg.sv
// Shared FFT constants and fixed-point helpers: pipeline depth, the Q-format
// range/rounding/saturation helpers, and the width constants derived from a sample width.
package fft_pkg;

    localparam int PIPE_DEPTH = 3;

    // Wide enough for every intermediate at the largest legal sample width (16 bits).
    localparam int ACC_W = 40;
    typedef logic signed [ACC_W-1:0] acc_t;

    function automatic int prod_w(input int bw);
        return 2 * bw;
    endfunction

    // Rescaled product and A +/- P carry two guard bits above the sample width.
    function automatic int sum_w(input int bw);
        return bw + 2;
    endfunction

    function automatic acc_t q_max(input int bw);
        return (acc_t'(1) <<< (bw - 1)) - acc_t'(1);
    endfunction

    function automatic acc_t q_min(input int bw);
        return -(acc_t'(1) <<< (bw - 1));
    endfunction

    // Arithmetic right shift, optionally adding half an LSB first (round half up).
    function automatic acc_t shr_round(input acc_t x, input int sh, input logic rnd);
        acc_t bias;
        bias = '0;
        if (rnd && sh > 0) bias = acc_t'(1) <<< (sh - 1);
        return (x + bias) >>> sh;
    endfunction

    function automatic logic out_of_range(input acc_t x, input int bw);
        return (x > q_max(bw)) || (x < q_min(bw));
    endfunction

    function automatic acc_t saturate(input acc_t x, input int bw);
        if (x > q_max(bw)) return q_max(bw);
        if (x < q_min(bw)) return q_min(bw);
        return x;
    endfunction

endpackage

// File: rtl/butterfly_pipe_cmul_stage.sv
// First pipeline stage of the butterfly: registers the four partial products
// of the complex multiply W*B; holds them whenever en is low.
module cmul_stage
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic signed [BIT_WIDTH-1:0]          b_re,
    input  logic signed [BIT_WIDTH-1:0]          b_im,
    input  logic signed [BIT_WIDTH-1:0]          w_re,
    input  logic signed [BIT_WIDTH-1:0]          w_im,
    output logic signed [prod_w(BIT_WIDTH)-1:0]  rr,
    output logic signed [prod_w(BIT_WIDTH)-1:0]  ii,
    output logic signed [prod_w(BIT_WIDTH)-1:0]  ri,
    output logic signed [prod_w(BIT_WIDTH)-1:0]  ir
);

    localparam int PW = prod_w(BIT_WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= '0;
            ii <= '0;
            ri <= '0;
            ir <= '0;
        end else if (en) begin
            rr <= PW'(w_re) * PW'(b_re);
            ii <= PW'(w_im) * PW'(b_im);
            ri <= PW'(w_re) * PW'(b_im);
            ir <= PW'(w_im) * PW'(b_re);
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 butterfly: out_a = A + W*B, out_b = A - W*B in Q1.(BIT_WIDTH-1).
// Define BUTTERFLY_PIPE_SAT_EN to saturate overflowing results instead of wrapping.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int ROUND     = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_scale,
    input  logic signed [BIT_WIDTH-1:0] a_re,
    input  logic signed [BIT_WIDTH-1:0] a_im,
    input  logic signed [BIT_WIDTH-1:0] b_re,
    input  logic signed [BIT_WIDTH-1:0] b_im,
    input  logic signed [BIT_WIDTH-1:0] w_re,
    input  logic signed [BIT_WIDTH-1:0] w_im,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BIT_WIDTH-1:0] out_a_re,
    output logic signed [BIT_WIDTH-1:0] out_a_im,
    output logic signed [BIT_WIDTH-1:0] out_b_re,
    output logic signed [BIT_WIDTH-1:0] out_b_im,
    output logic                        ovf_sticky,
    input  logic                        ovf_clr
);

    localparam int   PW  = prod_w(BIT_WIDTH);
    localparam int   SW  = sum_w(BIT_WIDTH);
    localparam logic RND = (ROUND != 0);

    // Handshake: a beat transfers on in_valid && in_ready, a result on
    // out_valid && out_ready. Every stage moves together when the output
    // register is empty or being drained; otherwise the whole pipe holds.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [PIPE_DEPTH-1:0]       stage_valid;
    logic                        s1_scale, s2_scale;
    logic signed [BIT_WIDTH-1:0] s1_a_re, s1_a_im;
    logic signed [PW-1:0]        rr, ii, ri, ir;
    logic signed [SW-1:0]        s2_sum [4];
    logic signed [SW-1:0]        sum_d [4];
    logic signed [BIT_WIDTH-1:0] red_d [4];
    logic [3:0]                  ovf_d;

    assign out_valid = stage_valid[PIPE_DEPTH-1];

    cmul_stage #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_cmul (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (adv),
        .b_re (b_re),
        .b_im (b_im),
        .w_re (w_re),
        .w_im (w_im),
        .rr   (rr),
        .ii   (ii),
        .ri   (ri),
        .ir   (ir)
    );

    // Component order in the arrays: a_re, a_im, b_re, b_im.
    always_comb begin
        acc_t p_re;
        acc_t p_im;
        p_re     = shr_round(acc_t'(rr) - acc_t'(ii), BIT_WIDTH - 1, RND);
        p_im     = shr_round(acc_t'(ri) + acc_t'(ir), BIT_WIDTH - 1, RND);
        sum_d[0] = SW'(acc_t'(s1_a_re) + p_re);
        sum_d[1] = SW'(acc_t'(s1_a_im) + p_im);
        sum_d[2] = SW'(acc_t'(s1_a_re) - p_re);
        sum_d[3] = SW'(acc_t'(s1_a_im) - p_im);
    end

    always_comb begin
        acc_t v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            v = acc_t'(s2_sum[k]);
            if (s2_scale) v = shr_round(v, 1, RND);
            ovf_d[k] = out_of_range(v, BIT_WIDTH);
`ifdef BUTTERFLY_PIPE_SAT_EN
            v = saturate(v, BIT_WIDTH);
`endif
            red_d[k] = v[BIT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            s1_scale    <= 1'b0;
            s2_scale    <= 1'b0;
            s1_a_re     <= '0;
            s1_a_im     <= '0;
            for (int k = 0; k < 4; k++) s2_sum[k] <= '0;
            out_a_re    <= '0;
            out_a_im    <= '0;
            out_b_re    <= '0;
            out_b_im    <= '0;
            ovf_sticky  <= 1'b0;
        end else begin
            if (adv) begin
                stage_valid <= {stage_valid[PIPE_DEPTH-2:0], in_valid};
                s1_scale    <= in_scale;
                s1_a_re     <= a_re;
                s1_a_im     <= a_im;
                s2_scale    <= s1_scale;
                for (int k = 0; k < 4; k++) s2_sum[k] <= sum_d[k];
                out_a_re    <= red_d[0];
                out_a_im    <= red_d[1];
                out_b_re    <= red_d[2];
                out_b_im    <= red_d[3];
            end
            // A fresh overflow beats a simultaneous clear.
            if (adv && stage_valid[1] && (|ovf_d)) ovf_sticky <= 1'b1;
            else if (ovf_clr)                      ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe (BIT_WIDTH=8, ROUND=1), either build.
`timescale 1ns/1ps
module tb_butterfly_pipe;
    localparam int BW = 8;
    localparam int EW = 4*BW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_scale = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0;
    logic [BW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
    logic in_ready, out_valid, ovf_sticky;
    logic [BW-1:0] out_a_re, out_a_im, out_b_re, out_b_im;

    int n_cmp = 0;
    int n_fail = 0;
    int n_out = 0;
    logic [EW-1:0] exp_q[$];

    // {ar, ai, br, bi, wr, wi, scale}
    logic [6*BW:0] tab [8] = '{
        {8'h10, 8'hF0, 8'h30, 8'h20, 8'h7F, 8'h00, 1'b0},
        {8'hE0, 8'h18, 8'h40, 8'hC0, 8'h5A, 8'hA6, 1'b1},
        {8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h00, 8'h7F, 1'b0},
        {8'h00, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1},
        {8'h33, 8'hCC, 8'h11, 8'hEE, 8'h40, 8'h40, 1'b0},
        {8'h80, 8'h7F, 8'h55, 8'hAA, 8'hA6, 8'h5A, 1'b1},
        {8'h05, 8'hFB, 8'h60, 8'hA0, 8'h7F, 8'h81, 1'b0},
        {8'hC0, 8'h40, 8'h20, 8'hE0, 8'h00, 8'h80, 1'b1}
    };

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    butterfly_pipe #(.BIT_WIDTH(BW), .ROUND(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_scale(in_scale),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a_re(out_a_re), .out_a_im(out_a_im),
        .out_b_re(out_b_re), .out_b_im(out_b_im),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    // ---------------- reference model ----------------
    function automatic int rsh(int x, int sh);
        return (x + (1 << (sh - 1))) >>> sh;
    endfunction

    function automatic logic [BW:0] reduce(int v);
        int hi = (1 << (BW - 1)) - 1;
        int lo = -(1 << (BW - 1));
        int r = v;
        logic o = (v > hi) || (v < lo);
`ifdef BUTTERFLY_PIPE_SAT_EN
        if (v > hi) r = hi;
        else if (v < lo) r = lo;
`endif
        return {o, r[BW-1:0]};
    endfunction

    function automatic logic [EW-1:0] model(logic [BW-1:0] ar, logic [BW-1:0] ai,
                                            logic [BW-1:0] br, logic [BW-1:0] bi,
                                            logic [BW-1:0] wr, logic [BW-1:0] wi,
                                            logic sc);
        int xa_r = int'($signed(ar));
        int xa_i = int'($signed(ai));
        int xb_r = int'($signed(br));
        int xb_i = int'($signed(bi));
        int xw_r = int'($signed(wr));
        int xw_i = int'($signed(wi));
        int p_r;
        int p_i;
        int s [4];
        logic [BW:0] r [4];
        logic o = 1'b0;
        p_r = rsh(xw_r*xb_r - xw_i*xb_i, BW - 1);
        p_i = rsh(xw_r*xb_i + xw_i*xb_r, BW - 1);
        s[0] = xa_r + p_r;
        s[1] = xa_i + p_i;
        s[2] = xa_r - p_r;
        s[3] = xa_i - p_i;
        for (int k = 0; k < 4; k++) begin
            if (sc) s[k] = rsh(s[k], 1);
            r[k] = reduce(s[k]);
            o = o | r[k][BW];
        end
        return {o, r[0][BW-1:0], r[1][BW-1:0], r[2][BW-1:0], r[3][BW-1:0]};
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    check("out_data", 64'({out_a_re, out_a_im, out_b_re, out_b_im}),
                          64'(exp_q[0][4*BW-1:0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, in_scale));
        end
    end

    // ---------------- drivers ----------------
    task automatic set_beat(logic [6*BW:0] t);
        {a_re, a_im, b_re, b_im, w_re, w_im, in_scale} = t;
    endtask

    task automatic single(logic [6*BW:0] t, logic clr_at_entry,
                          output logic [4*BW-1:0] res, output int lat);
        @(posedge clk); #1;
        in_valid = 1'b1;
        set_beat(t);
        @(negedge clk);
        check("accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 2 && clr_at_entry) ovf_clr = 1'b1;
        end while (!out_valid && lat < 10);
        ovf_clr = 1'b0;
        res = {out_a_re, out_a_im, out_b_re, out_b_im};
    endtask

    task automatic clear_pulse();
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        check("sticky_cleared", 64'(ovf_sticky), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [EW-1:0] pin;
        logic [4*BW-1:0] res;
        int lat;
        int sent;
        int cyc;
        int out0;
        int stale;

        // Hand-computed values pin the model itself.
        pin = model(8'h40, 8'h00, 8'h40, 8'h00, 8'h7F, 8'h00, 1'b0);
`ifdef BUTTERFLY_PIPE_SAT_EN
        check("model_pin_ovf", 64'(pin), 64'h1_7F00_0000);
`else
        check("model_pin_ovf", 64'(pin), 64'h1_8000_0000);
`endif
        pin = model(8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h80, 1'b0);
        check("model_pin_jw", 64'(pin), 64'h0_00E0_0020);

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_outputs", 64'({out_a_re, out_a_im, out_b_re, out_b_im}), 64'd0);
        check("rst_sticky", 64'(ovf_sticky), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 0.5 + 0.5*~1 overflows on out_a_re
        single({8'h40, 8'h00, 8'h40, 8'h00, 8'h7F, 8'h00, 1'b0}, 1'b0, res, lat);
        check("ovf_latency", 64'(lat), 64'd3);
`ifdef BUTTERFLY_PIPE_SAT_EN
        check("ovf_result", 64'(res), 64'h7F00_0000);
`else
        check("ovf_result", 64'(res), 64'h8000_0000);
`endif
        check("ovf_sticky_set", 64'(ovf_sticky), 64'd1);
        clear_pulse();

        // Same beat with stage scaling
        single({8'h40, 8'h00, 8'h40, 8'h00, 8'h7F, 8'h00, 1'b1}, 1'b0, res, lat);
        check("scale_latency", 64'(lat), 64'd3);
        check("scale_result", 64'(res), 64'h4000_0000);
        check("scale_sticky", 64'(ovf_sticky), 64'd0);

        // Multiply by -j
        single({8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h80, 1'b0}, 1'b0, res, lat);
        check("jw_result", 64'(res), 64'h00E0_0020);
        check("jw_sticky", 64'(ovf_sticky), 64'd0);

        // (-1)*(-1) rescales to +1.0
        single({8'h00, 8'h00, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0}, 1'b0, res, lat);
`ifdef BUTTERFLY_PIPE_SAT_EN
        check("m1m1_result", 64'(res), 64'h7F00_8000);
`else
        check("m1m1_result", 64'(res), 64'h8000_8000);
`endif
        check("m1m1_sticky", 64'(ovf_sticky), 64'd1);
        clear_pulse();
        // Clear coinciding with an overflowing beat entering the last stage
        single({8'h00, 8'h00, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0}, 1'b1, res, lat);
        check("set_wins", 64'(ovf_sticky), 64'd1);
        clear_pulse();

        // Back-to-back stream with a 4-cycle downstream stall
        sent = 0;
        cyc = 0;
        out0 = n_out;
        while ((sent < 8 || (n_out - out0) < 8) && cyc < 60) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 5 && cyc < 9);
            if (sent < 8) begin
                in_valid = 1'b1;
                set_beat(tab[sent]);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (!out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("stream_sent", 64'(sent), 64'd8);
        check("stream_received", 64'(n_out - out0), 64'd8);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            set_beat(tab[i]);
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_outputs", 64'({out_a_re, out_a_im, out_b_re, out_b_im}), 64'd0);
        check("midrst_sticky", 64'(ovf_sticky), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no_stale", 64'(stale), 64'd0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/butterfly_pipe.md
BUTTERFLY_PIPE -- requirements
Module: butterfly_pipe

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8: sample/twiddle width, signed Q1.(BIT_WIDTH-1), legal 4..16.
REQ-002 SHALL have parameter ROUND, default 1: 1 = round-half-up at every right shift, 0 = truncate.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; ports in order: clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-004 SHALL have ports:
 in_valid  input  1  input beat present
 in_ready  output 1  block accepts beat this cycle
 in_scale  input  1  1 = halve both results (per-beat FFT stage scaling)
 a_re, a_im, b_re, b_im  input  BIT_WIDTH each  operands A, B
 w_re, w_im  input  BIT_WIDTH each  twiddle W
 out_valid  output 1  result present
 out_ready  input  1  downstream accepts result
 out_a_re, out_a_im, out_b_re, out_b_im  output  BIT_WIDTH each  A+W*B, A-W*B
 ovf_sticky  output 1  overflow seen since last clear
 ovf_clr  input  1  synchronous clear of ovf_sticky

Function
REQ-005 SHALL compute P = W*B: P_re = w_re*b_re - w_im*b_im, P_im = w_re*b_im + w_im*b_re, full precision, 2*BIT_WIDTH+1 bits.
REQ-006 SHALL rescale P to Q.(BIT_WIDTH-1) by arithmetic right shift of BIT_WIDTH-1, adding 2^(BIT_WIDTH-2) first when ROUND=1; kept at BIT_WIDTH+2 bits.
REQ-007 SHALL form A+P and A-P at BIT_WIDTH+2 bits, sign-extending A.
REQ-008 SHALL, when the beat's in_scale=1, shift each sum right by 1 (adding 1 first when ROUND=1).
REQ-009 SHALL reduce each result to BIT_WIDTH bits per REQ-019; a result outside [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1] is an overflow.
REQ-010 SHALL be a 3-stage pipeline: S1 registers four partial products; S2 registers rescaled P and sums; S3 registers scaled, reduced outputs; latency exactly 3 cycles from accepted beat to out_valid with no stall.
REQ-011 SHALL accept a beat when in_valid && in_ready; in_scale travels with its beat.
REQ-012 SHALL advance all stages together when adv = !out_valid || out_ready; in_ready = adv (combinational, no in_valid dependency).
REQ-013 SHALL hold all stage registers and outputs stable while out_valid && !out_ready.
REQ-014 SHALL sustain one beat per cycle with out_ready held high; bubbles propagate as invalid stages.
REQ-015 SHALL set ovf_sticky in the cycle a beat with any overflowing component enters S3; ovf_clr clears it; simultaneous set and clear -> set wins.

Reset
REQ-016 SHALL on rst_n low clear all stage-valid bits, out_valid and ovf_sticky, and zero all four data outputs, asynchronously.
REQ-017 SHALL discard in-flight beats on reset mid-operation; none emerge after release.
REQ-018 SHALL drive in_ready=1 during and immediately after reset.

Configuration
REQ-019 SHALL, with macro BUTTERFLY_PIPE_SAT_EN defined, saturate overflowing results to 2^(BIT_WIDTH-1)-1 or -2^(BIT_WIDTH-1); without it, keep the low BIT_WIDTH bits (two's-complement wrap); overflow detection and ovf_sticky identical in both builds.

Structure
REQ-020 SHALL take the pipeline depth constant (3), Q-format helpers and the saturate/round width constants from shared package fft_pkg.
REQ-021 SHALL implement the S1 product stage as sub-module cmul_stage (registered complex multiply with enable); add/sub/scale/reduce stay in butterfly_pipe.

Verification (BIT_WIDTH=8, ROUND=1; S = sat build, W = wrap build)
REQ-022 SHALL check: A=(0x40,0), B=(0x40,0), W=(0x7F,0), scale=0 -> S: out_a=(0x7F,0x00), out_b=(0x00,0x00), ovf_sticky=1; W: out_a_re=0x80.
REQ-023 SHALL check: same beat with scale=1 -> out_a=(0x40,0x00), out_b=(0x00,0x00), ovf_sticky stays 0, 3 cycles after acceptance.
REQ-024 SHALL check: A=(0,0), B=(0x20,0), W=(0x00,0x80) -> out_a=(0x00,0xE0), out_b=(0x00,0x20).
REQ-025 SHALL check: B=(0x80,0), W=(0x80,0), A=0 -> out_a_re=0x7F (S), ovf_sticky=1; ovf_clr pulse together with a new overflowing beat entering S3 -> ovf_sticky stays 1.
REQ-026 SHALL check: 8 back-to-back beats, out_ready low for 4 cycles mid-stream -> outputs frozen, in_ready=0 during stall, all 8 results in order, none lost or duplicated.
REQ-027 SHALL check: rst_n asserted with 3 beats in flight -> out_valid=0 immediately, no stale result after release, in_ready=1.
